// File: rtl/regfile_sb.sv
// Parametrised register file with write-first bypass and a per-register busy scoreboard.
// Optional even-parity storage and checking is enabled by defining REGFILE_PARITY_EN.
module regfile_sb #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          rd1_busy,
    output logic          rd2_busy,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          flush,
`ifdef REGFILE_PARITY_EN
    input  logic          perr_inject,
    output logic          perr,
`endif
    output logic [AW:0]   pend_cnt
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    logic wr_eff, set_eff, inc, dec;
    logic z1, z2, byp1, byp2;

    assign wr_eff  = we && !(ZERO_REG && (wa == '0));
    assign set_eff = iss_valid && !(ZERO_REG && (iss_rd == '0));

    assign z1   = ZERO_REG && (ra1 == '0);
    assign z2   = ZERO_REG && (ra2 == '0);
    assign byp1 = wr_eff && (wa == ra1);
    assign byp2 = wr_eff && (wa == ra2);

    assign rd1 = z1 ? '0 : (byp1 ? wd : mem_q[ra1]);
    assign rd2 = z2 ? '0 : (byp2 ? wd : mem_q[ra2]);

    // A register written back this cycle has its producer retiring now, so it reads ready.
    assign rd1_busy = !z1 && busy_q[ra1] && !byp1;
    assign rd2_busy = !z2 && busy_q[ra2] && !byp2;

    // Counter tracks popcount incrementally: a same-register set+clear nets to no change.
    assign inc = set_eff && !busy_q[iss_rd];
    assign dec = wr_eff && busy_q[wa] && !(set_eff && (iss_rd == wa));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_eff)  busy_d[wa]     = 1'b0;
            if (set_eff) busy_d[iss_rd] = 1'b1;
            cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_eff) mem_q[wa] <= wd;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             pe1, pe2;

    always_ff @(posedge clk) begin
        if (rst)         par_q     <= '0;
        else if (wr_eff) par_q[wa] <= (^wd) ^ perr_inject;
    end

    assign pe1  = (par_q[ra1] != (^mem_q[ra1])) && !byp1 && !z1;
    assign pe2  = (par_q[ra2] != (^mem_q[ra2])) && !byp2 && !z2;
    assign perr = pe1 || pe2;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed plan steps, then random traffic against a model.
// Parity checks are compiled in when REGFILE_PARITY_EN is defined.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst, we, iss_valid, flush;
    logic [4:0]  ra1, ra2, wa, iss_rd;
    logic [31:0] wd, rd1, rd2;
    logic        rd1_busy, rd2_busy;
    logic [5:0]  pend_cnt;
`ifdef REGFILE_PARITY_EN
    logic        perr_inject, perr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    bit          m_pbad [32];

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
`ifdef REGFILE_PARITY_EN
        .perr_inject(perr_inject), .perr(perr),
`endif
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wr();
        return we && (wa != 5'd0);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_wr() && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic m_bsy(input logic [4:0] a);
        return (a != 5'd0) && m_busy[a] && !(m_wr() && wa == a);
    endfunction

    function automatic int m_pop();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

`ifdef REGFILE_PARITY_EN
    function automatic logic m_perr();
        logic e1, e2;
        e1 = (ra1 != 5'd0) && !(m_wr() && wa == ra1) && m_pbad[ra1];
        e2 = (ra2 != 5'd0) && !(m_wr() && wa == ra2) && m_pbad[ra2];
        return e1 || e2;
    endfunction
`endif

    // Apply the behavioural rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'd0; m_busy[i] = 1'b0; m_pbad[i] = 1'b0;
            end
        end else begin
            if (m_wr()) begin
                m_mem[wa] = wd;
`ifdef REGFILE_PARITY_EN
                m_pbad[wa] = perr_inject;
`endif
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (m_wr()) m_busy[wa] = 1'b0;
                if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; wa = 0; wd = 0; iss_valid = 0; iss_rd = 0; flush = 0;
`ifdef REGFILE_PARITY_EN
        perr_inject = 0;
`endif
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rd1"}, rd1, m_rd(ra1));
        chk({tag, ".rd2"}, rd2, m_rd(ra2));
        chk({tag, ".b1"}, {31'd0, rd1_busy}, {31'd0, m_bsy(ra1)});
        chk({tag, ".b2"}, {31'd0, rd2_busy}, {31'd0, m_bsy(ra2)});
        chk({tag, ".cnt"}, {26'd0, pend_cnt}, m_pop());
`ifdef REGFILE_PARITY_EN
        chk({tag, ".perr"}, {31'd0, perr}, {31'd0, m_perr()});
`endif
    endtask

    initial begin
        idle();
        ra1 = 0; ra2 = 0;
        rst = 1;
        tick();
        // Writeback and issue during reset must be ignored.
        we = 1; wa = 6; wd = 32'hFFFF_0000; iss_valid = 1; iss_rd = 6;
        tick();
        idle(); rst = 0;
        ra1 = 0; ra2 = 31; #1;
        chk("rst.rd1", rd1, 32'd0);
        chk("rst.rd2", rd2, 32'd0);
        chk("rst.b1", {31'd0, rd1_busy}, 32'd0);
        chk("rst.b2", {31'd0, rd2_busy}, 32'd0);
        chk("rst.cnt", {26'd0, pend_cnt}, 32'd0);
        ra2 = 6; #1;
        chk("rst.ignwe", rd2, 32'd0);
        chk("rst.ignis", {31'd0, rd2_busy}, 32'd0);

        we = 1; wa = 5; wd = 32'hDEAD_BEEF; ra1 = 5; ra2 = 0; #1;
        chk("byp.rd1", rd1, 32'hDEAD_BEEF);
        tick();
        idle(); #1;
        chk("wr.rd1", rd1, 32'hDEAD_BEEF);

        we = 1; wa = 0; wd = 32'h1234; ra1 = 0; #1;
        chk("z.byp", rd1, 32'd0);
        tick();
        idle(); #1;
        chk("z.rd", rd1, 32'd0);

        iss_valid = 1; iss_rd = 3; tick();
        iss_rd = 7; tick();
        idle(); ra1 = 3; ra2 = 7; #1;
        chk("sb.cnt2", {26'd0, pend_cnt}, 32'd2);
        chk("sb.b1", {31'd0, rd1_busy}, 32'd1);
        chk("sb.b2", {31'd0, rd2_busy}, 32'd1);
        we = 1; wa = 3; wd = 32'h33; #1;
        chk("sb.wbfree", {31'd0, rd1_busy}, 32'd0);
        chk("sb.wbdata", rd1, 32'h33);
        tick();
        idle(); #1;
        chk("sb.cnt1", {26'd0, pend_cnt}, 32'd1);
        chk("sb.b1clr", {31'd0, rd1_busy}, 32'd0);

        iss_valid = 1; iss_rd = 7; we = 1; wa = 7; wd = 32'h77; tick();
        idle(); ra2 = 7; #1;
        chk("sc.busy7", {31'd0, rd2_busy}, 32'd1);
        chk("sc.cnt", {26'd0, pend_cnt}, 32'd1);
        chk("sc.rd7", rd2, 32'h77);

        iss_valid = 1; iss_rd = 0; tick();
        idle(); ra1 = 0; #1;
        chk("z.nobusy", {31'd0, rd1_busy}, 32'd0);
        chk("z.cnt", {26'd0, pend_cnt}, 32'd1);

        // Issue on a busy register must not bump the count.
        iss_valid = 1; iss_rd = 7; tick();
        idle(); #1;
        chk("re.cnt", {26'd0, pend_cnt}, 32'd1);
        // Writeback to a register that is not busy must not decrement.
        we = 1; wa = 12; wd = 32'hC; tick();
        idle(); #1;
        chk("wnb.cnt", {26'd0, pend_cnt}, 32'd1);

        iss_valid = 1; iss_rd = 9; flush = 1; we = 1; wa = 10; wd = 32'hA5A5; tick();
        idle(); ra1 = 9; ra2 = 7; #1;
        chk("fl.cnt", {26'd0, pend_cnt}, 32'd0);
        chk("fl.b9", {31'd0, rd1_busy}, 32'd0);
        chk("fl.b7", {31'd0, rd2_busy}, 32'd0);
        ra1 = 10; #1;
        chk("fl.data", rd1, 32'hA5A5);

        // Fill every non-zero register to reach the counter ceiling.
        for (int i = 0; i < 32; i++) begin
            iss_valid = 1; iss_rd = 5'(i); tick();
        end
        idle(); #1;
        chk("full.cnt", {26'd0, pend_cnt}, 32'd31);
        chk_all("full");

`ifdef REGFILE_PARITY_EN
        we = 1; wa = 4; wd = 32'h0000_0F0F; perr_inject = 1; ra1 = 4; ra2 = 0; #1;
        chk("par.byp", {31'd0, perr}, 32'd0);
        tick();
        idle(); ra1 = 4; #1;
        chk("par.inj", {31'd0, perr}, 32'd1);
        we = 1; wa = 4; wd = 32'h0000_0F0F; tick();
        idle(); #1;
        chk("par.fix", {31'd0, perr}, 32'd0);
`endif

        // Random traffic concentrated on a few registers so hazards collide often.
        for (int n = 0; n < 400; n++) begin
            we        = 1'($urandom_range(0, 1));
            wa        = 5'($urandom_range(0, 7));
            wd        = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 19) == 0);
            ra1       = 5'($urandom_range(0, 7));
            ra2       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
`ifdef REGFILE_PARITY_EN
            perr_inject = ($urandom_range(0, 7) == 0);
`endif
            #1;
            chk_all("rnd");
            tick();
        end

        idle(); rst = 1; tick();
        rst = 0; ra1 = 3; ra2 = 5; #1;
        chk_all("rst2");
        chk("rst2.cnt", {26'd0, pend_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
